// File: rtl/player_motion_pkg.sv
// Shared video-controller definitions: direction bit indices, playfield size
// and the player motion FSM state type.
package player_motion_pkg;

    localparam int DIR_UP    = 0;
    localparam int DIR_DOWN  = 1;
    localparam int DIR_LEFT  = 2;
    localparam int DIR_RIGHT = 3;

    localparam int PLAYFIELD_W = 640;
    localparam int PLAYFIELD_H = 480;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        COMMIT = 2'd2
    } motion_state_t;

endpackage

// File: rtl/player_motion_button_debounce.sv
// Two-flop synchronizer plus stability counter for one raw push button.
// The debounced level follows the synced input after DEBOUNCE stable cycles.
module button_debounce #(
    parameter int DEBOUNCE = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic btn_o
);

    localparam int CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             db_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            // Any cycle where the synced level matches the accepted one restarts the count.
            if (sync2_q == db_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                db_q  <= sync2_q;
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign btn_o = db_q;

endmodule

// File: rtl/player_motion.sv
// Player position stage: debounced buttons move the player once per frame on the
// VSYNC falling edge, clamped to the playfield (horizontal wraps if PLAYER_MOTION_WRAP_EN).
module player_motion
    import player_motion_pkg::*;
#(
    parameter int H_MIN    = 0,
    parameter int H_MAX    = PLAYFIELD_W,
    parameter int V_MIN    = 0,
    parameter int V_MAX    = PLAYFIELD_H,
    parameter int OBJ_W    = 16,
    parameter int OBJ_H    = 16,
    parameter int STEP     = 2,
    parameter int H_START  = 312,
    parameter int V_START  = 232,
    parameter int DEBOUNCE = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  btns,
    input  logic        VS,
    input  logic [3:0]  blocked,
    output logic [11:0] player_vStartPos,
    output logic [11:0] player_hStartPos,
    output logic        moving,
    output logic        frame_tick,
    output logic [1:0]  dbg_state_o
);

    localparam logic [11:0] H_LO   = 12'(H_MIN);
    localparam logic [11:0] H_HI   = 12'(H_MAX - OBJ_W);
    localparam logic [11:0] V_LO   = 12'(V_MIN);
    localparam logic [11:0] V_HI   = 12'(V_MAX - OBJ_H);
    localparam logic [11:0] STEP12 = 12'(STEP);
`ifdef PLAYER_MOTION_WRAP_EN
    localparam logic WRAP_H = 1'b1;
`else
    localparam logic WRAP_H = 1'b0;
`endif

    // Comparisons run at 13 bits so pos+step never overflows near the limits.
    function automatic logic [11:0] step_axis(
        input logic [11:0] pos,
        input logic        inc,
        input logic        dec,
        input logic [11:0] lo,
        input logic [11:0] hi,
        input logic        wrap
    );
        logic [12:0] up;
        logic [12:0] lo_plus;
        logic [11:0] r;
        up      = {1'b0, pos} + {1'b0, STEP12};
        lo_plus = {1'b0, lo} + {1'b0, STEP12};
        r       = pos;
        if (inc) begin
            if (up > {1'b0, hi}) r = wrap ? lo : hi;
            else                 r = up[11:0];
        end else if (dec) begin
            if ({1'b0, pos} < lo_plus) r = wrap ? hi : lo;
            else                       r = pos - STEP12;
        end
        return r;
    endfunction

    logic [3:0]    btn_db;
    logic          vs_q;
    motion_state_t state_q;
    logic [3:0]    btn_q;
    logic [3:0]    blk_q;
    logic [11:0]   h_q, v_q;
    logic [11:0]   h_cand_q, v_cand_q;
    logic [11:0]   h_cand_d, v_cand_d;
    logic          moving_q;
    logic          inc_h, dec_h, inc_v, dec_v;

    for (genvar i = 0; i < 4; i++) begin : g_db
        button_debounce #(.DEBOUNCE(DEBOUNCE)) u_db (
            .clk   (clk),
            .rst   (rst),
            .btn_i (btns[i]),
            .btn_o (btn_db[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) vs_q <= 1'b1;
        else     vs_q <= VS;
    end

    assign frame_tick = vs_q & ~VS & ~rst;

    // Opposite directions cancel; a blocked direction is simply not taken.
    assign inc_h = btn_q[DIR_RIGHT] & ~btn_q[DIR_LEFT]  & ~blk_q[DIR_RIGHT];
    assign dec_h = btn_q[DIR_LEFT]  & ~btn_q[DIR_RIGHT] & ~blk_q[DIR_LEFT];
    assign inc_v = btn_q[DIR_DOWN]  & ~btn_q[DIR_UP]    & ~blk_q[DIR_DOWN];
    assign dec_v = btn_q[DIR_UP]    & ~btn_q[DIR_DOWN]  & ~blk_q[DIR_UP];

    always_comb begin
        h_cand_d = step_axis(h_q, inc_h, dec_h, H_LO, H_HI, WRAP_H);
        v_cand_d = step_axis(v_q, inc_v, dec_v, V_LO, V_HI, 1'b0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            btn_q    <= 4'b0000;
            blk_q    <= 4'b0000;
            h_cand_q <= 12'(H_START);
            v_cand_q <= 12'(V_START);
            h_q      <= 12'(H_START);
            v_q      <= 12'(V_START);
            moving_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (frame_tick) begin
                        btn_q   <= btn_db;
                        blk_q   <= blocked;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    h_cand_q <= h_cand_d;
                    v_cand_q <= v_cand_d;
                    state_q  <= COMMIT;
                end
                COMMIT: begin
                    h_q      <= h_cand_q;
                    v_q      <= v_cand_q;
                    moving_q <= (h_cand_q != h_q) || (v_cand_q != v_q);
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign player_hStartPos = h_q;
    assign player_vStartPos = v_q;
    assign moving           = moving_q;
    assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_player_motion.sv
// Bench for player_motion: frame-level position model checked every cycle, plus
// directed scenarios with literal expectations (honours PLAYER_MOTION_WRAP_EN).
module tb_player_motion;

`ifdef PLAYER_MOTION_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif
  localparam int H_LIM = 640 - 16;
  localparam int V_LIM = 480 - 16;

  logic        clk;
  logic        rst;
  logic [3:0]  btns;
  logic        VS;
  logic [3:0]  blocked;
  logic [11:0] vpos;
  logic [11:0] hpos;
  logic        moving;
  logic        frame_tick;
  logic [1:0]  dbg_state;

  int n_vec;
  int n_err;

  player_motion #(.DEBOUNCE(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .btns             (btns),
    .VS               (VS),
    .blocked          (blocked),
    .player_vStartPos (vpos),
    .player_hStartPos (hpos),
    .moving           (moving),
    .frame_tick       (frame_tick),
    .dbg_state_o      (dbg_state)
  );

  // clock / reset / vsync
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    VS = 1'b1;
    forever begin
      repeat (97) @(posedge clk);
      #1 VS = 1'b0;
      repeat (3) @(posedge clk);
      #1 VS = 1'b1;
    end
  end

  // frame-level model: btn_held is the button set the bench holds steadily
  logic [3:0] btn_held;
  int m_h = 312;
  int m_v = 232;
  bit m_moving = 1'b0;
  bit m_vs = 1'b1;
  int m_pend = 0;
  int m_nh = 312;
  int m_nv = 232;
  int m_frames = 0;

  function automatic int axis(int p, bit inc, bit dec, bit binc, bit bdec, int hi, bit wrap);
    if (inc && !dec && !binc) begin
      if (p + 2 > hi) return wrap ? 0 : hi;
      return p + 2;
    end
    if (dec && !inc && !bdec) begin
      if (p < 2) return wrap ? hi : 0;
      return p - 2;
    end
    return p;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_h <= 312; m_v <= 232; m_moving <= 1'b0; m_vs <= 1'b1; m_pend <= 0;
    end else begin
      if (m_pend == 1) begin
        m_moving <= (m_nh != m_h) || (m_nv != m_v);
        m_h <= m_nh;
        m_v <= m_nv;
        m_frames <= m_frames + 1;
      end
      if (m_pend > 0) begin
        m_pend <= m_pend - 1;
      end else if (m_vs && !VS) begin
        m_nh <= axis(m_h, btn_held[3], btn_held[2], blocked[3], blocked[2], H_LIM, WRAP);
        m_nv <= axis(m_v, btn_held[1], btn_held[0], blocked[1], blocked[0], V_LIM, 1'b0);
        m_pend <= 2;
      end
      m_vs <= VS;
    end
  end

  // scoreboard
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("hpos", {20'd0, hpos}, m_h);
    check("vpos", {20'd0, vpos}, m_v);
    check("moving", {31'd0, moving}, {31'd0, m_moving});
    check("frame_tick", {31'd0, frame_tick}, {31'd0, m_vs & ~VS & ~rst});
  end

  // driver tasks
  task automatic frames(input int n);
    int target;
    int budget;
    target = m_frames + n;
    budget = n * 100 + 300;
    while (m_frames < target && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (m_frames < target) begin
      n_vec++; n_err++;
      $display("FAIL frames_timeout: got %0d expected %0d", m_frames, target);
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_tick(output bit ok);
    int budget;
    budget = 300;
    ok = 1'b0;
    while (!ok && budget > 0) begin
      @(negedge clk);
      ok = frame_tick;
      budget--;
    end
    if (!ok) begin
      n_vec++; n_err++;
      $display("FAIL tick_timeout: got 0 expected 1");
    end
  endtask

  task automatic set_btns(input logic [3:0] b);
    btns = b;
    btn_held = b;
  endtask

  int tick_cnt;
  bit count_ticks;
  always @(negedge clk) if (count_ticks && frame_tick) tick_cnt++;

  initial begin
    bit ok;
    n_vec = 0; n_err = 0; tick_cnt = 0; count_ticks = 1'b0;
    rst = 1'b1; btns = 4'b0000; btn_held = 4'b0000; blocked = 4'b0000;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_h", {20'd0, hpos}, 312);
    check("reset_v", {20'd0, vpos}, 232);
    check("reset_moving", {31'd0, moving}, 0);

    // idle frames
    count_ticks = 1'b1;
    frames(3);
    count_ticks = 1'b0;
    check("idle_ticks", tick_cnt, 3);
    check("idle_h", {20'd0, hpos}, 312);
    check("idle_v", {20'd0, vpos}, 232);
    check("idle_moving", {31'd0, moving}, 0);

    // hold right: first update lands two cycles after the tick edge
    set_btns(4'b1000);
    wait_tick(ok);
    @(negedge clk);
    check("lat_calc_h", {20'd0, hpos}, 312);
    @(negedge clk);
    check("lat_commit_h", {20'd0, hpos}, 312);
    @(negedge clk);
    check("lat_out_h", {20'd0, hpos}, 314);
    frames(4);
    check("right5_h", {20'd0, hpos}, 322);
    check("right5_moving", {31'd0, moving}, 1);

    // left+right cancel, then add up
    set_btns(4'b1100);
    frames(1);
    check("lr_h", {20'd0, hpos}, 322);
    check("lr_moving", {31'd0, moving}, 0);
    set_btns(4'b1101);
    frames(2);
    check("up_v", {20'd0, vpos}, 228);
    check("up_h", {20'd0, hpos}, 322);

    // right edge
    set_btns(4'b1000);
    frames(151);
    check("right_edge_h", {20'd0, hpos}, 624);
    frames(1);
    check("right_past_h", {20'd0, hpos}, WRAP ? 0 : 624);
    frames(2);
    check("right_after_h", {20'd0, hpos}, WRAP ? 4 : 624);
    check("right_after_moving", {31'd0, moving}, WRAP ? 1 : 0);

    // left edge
    set_btns(4'b0100);
    frames(313);
    check("left_edge_h", {20'd0, hpos}, WRAP ? 4 : 0);
    check("left_edge_moving", {31'd0, moving}, WRAP ? 1 : 0);

    // blocked down, then released
    set_btns(4'b0010);
    blocked = 4'b0010;
    frames(2);
    check("blocked_v", {20'd0, vpos}, 228);
    check("blocked_moving", {31'd0, moving}, 0);
    blocked = 4'b0000;
    frames(2);
    check("unblocked_v", {20'd0, vpos}, 232);

    // 2-cycle glitch on right is rejected
    set_btns(4'b0000);
    frames(1);
    btns = 4'b1000;
    repeat (2) @(posedge clk);
    #1 btns = 4'b0000;
    frames(1);
    check("glitch_h", {20'd0, hpos}, WRAP ? 4 : 0);
    check("glitch_moving", {31'd0, moving}, 0);

    // reset between tick and commit abandons the update
    set_btns(4'b1000);
    wait_tick(ok);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("midrst_h", {20'd0, hpos}, 312);
    check("midrst_v", {20'd0, vpos}, 232);
    check("midrst_moving", {31'd0, moving}, 0);
    frames(1);
    check("postrst_h", {20'd0, hpos}, 314);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
